ram_fifo_ctrl: RTL
==================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the word width, which matches the RAM data width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, the RAM address width; depth DEPTH = 2**ADDR_W (8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and din (input, DATA_W): the upstream push handshake.
REQ-006 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and dout (output, DATA_W): the downstream pop handshake.
REQ-007 The block SHALL have ports full (output, 1) and empty (output, 1): RAM occupancy flags derived from count.
REQ-008 The block SHALL have RAM-side ports ram_wr_en (output, 1), ram_addr (output, ADDR_W), ram_data_in (output, DATA_W) and ram_data_out (input, DATA_W), which connect to the single-port RAM.

Function
REQ-009 The block SHALL treat the RAM as single-port, with write synchronous on clk and read combinational (ram_data_out = mem[ram_addr]).
REQ-010 The block SHALL hold the internal state wr_ptr and rd_ptr (ADDR_W each, wrapping DEPTH-1 -> 0), count (ADDR_W+1 bits, 0..DEPTH) and the output register dout/out_valid.
REQ-011 The block SHALL define fill = (count != 0) && (!out_valid || out_ready), and SHALL perform at most one RAM operation per cycle, with fill having priority over push.
REQ-012 The block SHALL drive in_ready = (count != DEPTH) && !fill && !rst, combinationally.
REQ-013 The block SHALL define push = in_valid && in_ready, and SHALL drive ram_wr_en = push, ram_addr = fill ? rd_ptr : wr_ptr, and ram_data_in = din.
REQ-014 On push, the block SHALL write din at wr_ptr at the clock edge, increment wr_ptr, and increment count.
REQ-015 On fill, the block SHALL load dout with ram_data_out, set out_valid to 1, increment rd_ptr, and decrement count.
REQ-016 If out_valid && out_ready && !fill, the block SHALL clear out_valid to 0 at the edge and hold dout.
REQ-017 While out_valid && !out_ready, the block SHALL hold dout and out_valid stable.
REQ-018 Latency: a word accepted at edge k SHALL appear with out_valid=1 after edge k+1, given an empty block and out_ready=1.
REQ-019 The block SHALL drive full = (count == DEPTH) and empty = (count == 0); the word held in dout is not counted.
REQ-020 When full, in_ready SHALL be 0, no write SHALL occur, and pointers SHALL hold.
REQ-021 When empty, no fill SHALL occur, and out_valid SHALL drain per REQ-016.
REQ-022 When in_valid and a fill condition coincide, the block SHALL perform the fill, keep in_ready=0, leave din unaccepted, and require upstream to hold din.
REQ-023 Ordering SHALL be strict FIFO across pointer wrap-around.

Reset
REQ-024 While rst=1 at an edge, the block SHALL set wr_ptr=0, rd_ptr=0, count=0, out_valid=0 and dout=0.
REQ-025 While rst=1, the block SHALL hold ram_wr_en=0 and in_ready=0, so no RAM write occurs in a reset cycle.
REQ-026 Reset asserted mid-stream SHALL discard all stored words; RAM contents are not cleared.
REQ-027 After reset, the block SHALL drive full=0 and empty=1, with in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-028 The block SHALL provide macro RAM_FIFO_LEVEL_EN, which when defined adds output port level (ADDR_W+1 bits) = count + out_valid, saturating at DEPTH+1, reset value 0.
REQ-029 Without RAM_FIFO_LEVEL_EN, the level port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 After reset, pushing 100, 50, 255 with out_ready=0 SHALL produce ram_wr_en pulses at addresses 0, 1, 2; dout SHALL be 100 with out_valid=1, and count SHALL be 2.
REQ-031 Raising out_ready with no pushes SHALL pop 100, 50, 255 in order on consecutive handshakes; empty=1 and out_valid=0 SHALL follow afterwards.
REQ-032 Pushing 9 words 1..9 with out_ready=0 SHALL hold word 1 in dout, leave 2..9 in RAM, give full=1 and in_ready=0, and reject word 10.
REQ-033 Streaming 20 words with in_valid=1 and out_ready=1 SHALL output 1..20 in order across pointer wrap, with no word lost or duplicated.
REQ-034 Asserting rst for 1 cycle with 4 words stored SHALL give out_valid=0, empty=1 and ram_wr_en=0 in that cycle; the next push SHALL go to address 0.
REQ-035 With RAM_FIFO_LEVEL_EN defined, 3 pushes and 1 pop SHALL give level=2.

Source files
------------

// File: rtl/ram_fifo_if.sv
// ram_fifo_if -- handshake and RAM-side bundle for ram_fifo_ctrl.
//
// Purpose: groups the upstream push handshake, the downstream pop handshake,
// the occupancy flags and the single-port RAM connection into one bundle.
//
// Signals:
//   in_valid / in_ready / din     upstream push handshake
//   out_valid / out_ready / dout  downstream pop handshake
//   full / empty                  RAM occupancy flags (the word held in dout is not counted)
//   ram_wr_en / ram_addr /
//   ram_data_in / ram_data_out    single-port RAM (synchronous write, combinational read)
//   level                         words held = RAM count + output register
//                                 (present only when RAM_FIFO_LEVEL_EN is defined)
//
// Modports:
//   slave  -- the FIFO controller side
//   master -- the environment side (producer, consumer and RAM)
interface ram_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;
`ifdef RAM_FIFO_LEVEL_EN
  logic [ADDR_W:0]   level;

  modport slave (
    input  in_valid, din, out_ready, ram_data_out,
    output in_ready, out_valid, dout, full, empty,
           ram_wr_en, ram_addr, ram_data_in, level
  );

  modport master (
    output in_valid, din, out_ready, ram_data_out,
    input  in_ready, out_valid, dout, full, empty,
           ram_wr_en, ram_addr, ram_data_in, level
  );
`else
  modport slave (
    input  in_valid, din, out_ready, ram_data_out,
    output in_ready, out_valid, dout, full, empty,
           ram_wr_en, ram_addr, ram_data_in
  );

  modport master (
    output in_valid, din, out_ready, ram_data_out,
    input  in_ready, out_valid, dout, full, empty,
           ram_wr_en, ram_addr, ram_data_in
  );
`endif
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl -- FIFO controller around an external single-port RAM.
//
// Purpose: stores words in a DEPTH = 2**ADDR_W entry single-port RAM and
// presents them through a registered output stage (dout/out_valid). The RAM
// does one operation per cycle: a read into the output register ("fill") has
// priority over a write from upstream ("push").
//
// Ports:
//   clk  -- single clock, rising edge
//   rst  -- synchronous, active-high reset
//   bus  -- ram_fifo_if.slave: push/pop handshakes, full/empty flags,
//           RAM write enable/address/data, and optional level
//
// Optional feature macro: RAM_FIFO_LEVEL_EN
//   When defined, bus.level = count + out_valid (saturating at DEPTH+1).
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  ram_fifo_if.slave  bus
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] dout_p1;
  logic              vld_p1;
  logic              fill;
  logic              push;
  logic              in_ready;

  // Refill the output register whenever it is empty or being consumed this
  // cycle; this owns the RAM port, so upstream is stalled for that cycle.
  assign fill     = (count != '0) && (!vld_p1 || bus.out_ready);
  assign in_ready = (count != CNT_FULL) && !fill && !rst;
  assign push     = bus.in_valid && in_ready;

  assign bus.in_ready    = in_ready;
  assign bus.ram_wr_en   = push;
  assign bus.ram_addr    = fill ? rd_ptr : wr_ptr;
  assign bus.ram_data_in = bus.din;
  assign bus.out_valid   = vld_p1;
  assign bus.dout        = dout_p1;
  assign bus.full        = (count == CNT_FULL);
  assign bus.empty       = (count == '0);

  // ---- stage p1: pointers, RAM count and output register ----
  // push and fill are mutually exclusive, so count sees at most one update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      vld_p1  <= 1'b0;
      dout_p1 <= '0;
    end else begin
      if (fill) begin
        dout_p1 <= bus.ram_data_out;
        vld_p1  <= 1'b1;
        rd_ptr  <= rd_ptr + PTR_ONE;
        count   <= count - CNT_ONE;
      end else if (vld_p1 && bus.out_ready) begin
        vld_p1  <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        count  <= count + CNT_ONE;
      end
    end
  end

`ifdef RAM_FIFO_LEVEL_EN
  localparam logic [ADDR_W+1:0] LEVEL_MAX = (ADDR_W+2)'(DEPTH + 1);

  // Total words held, clamped to DEPTH+1 (RAM full plus the output register).
  function automatic logic [ADDR_W:0] sat_level(input logic [ADDR_W:0] cnt,
                                                input logic            vld);
    logic [ADDR_W+1:0] sum;
    sum = {1'b0, cnt} + {{(ADDR_W+1){1'b0}}, vld};
    if (sum > LEVEL_MAX) begin
      return LEVEL_MAX[ADDR_W:0];
    end
    return sum[ADDR_W:0];
  endfunction

  assign bus.level = sat_level(count, vld_p1);
`endif

endmodule
